// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port plus a per-register busy scoreboard.
// Accept-to-write latency is one cycle; a loser is held off by READY low until it wins.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req0_valid,
    input  logic [AW-1:0] i_req0_addr,
    input  logic [DW-1:0] i_req0_data,
    output logic          o_req0_ready,
    input  logic          i_req1_valid,
    input  logic [AW-1:0] i_req1_addr,
    input  logic [DW-1:0] i_req1_data,
    output logic          o_req1_ready,
    input  logic          i_issue_valid,
    input  logic [AW-1:0] i_issue_addr,
    output logic          o_issue_ready,
    input  logic [AW-1:0] i_rs1,
    input  logic [AW-1:0] i_rs2,
    output logic          o_rs1_busy,
    output logic          o_rs2_busy,
    output logic          o_rf_we,
    output logic [AW-1:0] o_rf_a3,
    output logic [DW-1:0] o_rf_wd3
);
    localparam int NREG = 2 ** AW;

    logic            r_last_gnt;
    logic [NREG-1:0] r_busy;
    logic            r_rf_we;
    logic [AW-1:0]   r_rf_a3;
    logic [DW-1:0]   r_rf_wd3;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_xfer;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic            w_issue_set;
    logic [NREG-1:0] w_busy_nxt;

    // r_last_gnt=1 means requester 1 won most recently, so requester 0 has priority on a tie
    assign w_gnt0 = i_req0_valid & (~i_req1_valid | r_last_gnt);
    assign w_gnt1 = i_req1_valid & (~i_req0_valid | ~r_last_gnt);
    assign w_xfer = w_gnt0 | w_gnt1;
    assign w_addr = w_gnt1 ? i_req1_addr : i_req0_addr;
    assign w_data = w_gnt1 ? i_req1_data : i_req0_data;

    assign o_req0_ready  = w_gnt0;
    assign o_req1_ready  = w_gnt1;
    assign o_issue_ready = (i_issue_addr == '0) | ~r_busy[i_issue_addr];
    assign w_issue_set   = i_issue_valid & o_issue_ready & (i_issue_addr != '0);
    assign o_rs1_busy    = r_busy[i_rs1];
    assign o_rs2_busy    = r_busy[i_rs2];
    assign o_rf_we       = r_rf_we;
    assign o_rf_a3       = r_rf_a3;
    assign o_rf_wd3      = r_rf_wd3;

    // Clear applied before set so a new producer issued on the landing edge stays tracked
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_rf_we) begin
            w_busy_nxt[r_rf_a3] = 1'b0;
        end
        if (w_issue_set) begin
            w_busy_nxt[i_issue_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_gnt <= 1'b1;
            r_busy     <= '0;
            r_rf_we    <= 1'b0;
            r_rf_a3    <= '0;
            r_rf_wd3   <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_rf_we <= w_xfer & (w_addr != '0);
            if (w_xfer) begin
                r_last_gnt <= w_gnt1;
                r_rf_a3    <= w_addr;
                r_rf_wd3   <= w_data;
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a reference model predicts grants, issue acceptance and busy bits,
// and queues expected register-file writes for an independent monitor.
module tb_rf_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid, issue_valid;
    logic [AW-1:0] req0_addr, req1_addr, issue_addr, rs1, rs2;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready, issue_ready, rs1_busy, rs2_busy;
    logic          rf_we;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd3;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(req0_valid), .i_req0_addr(req0_addr), .i_req0_data(req0_data), .o_req0_ready(req0_ready),
        .i_req1_valid(req1_valid), .i_req1_addr(req1_addr), .i_req1_data(req1_data), .o_req1_ready(req1_ready),
        .i_issue_valid(issue_valid), .i_issue_addr(issue_addr), .o_issue_ready(issue_ready),
        .i_rs1(rs1), .i_rs2(rs2), .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
        .o_rf_we(rf_we), .o_rf_a3(rf_a3), .o_rf_wd3(rf_wd3)
    );

    typedef struct {
        int            cyc;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           exp_q[$];
    int            cyc = 0;
    int            passes = 0;
    int            total = 0;
    logic [AW-1:0] mon_a3 = '0;
    logic [DW-1:0] mon_wd3 = '0;

    // Reference model state
    int m_last;
    bit m_busy[32];
    int m_clr;
    bit g0_l, g1_l;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passes++;
        else $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    endtask

    // Monitor: every cycle the write port must match the next queued write or stay idle and hold
    always @(negedge clk) begin
        wr_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e       = exp_q.pop_front();
            mon_a3  = e.a;
            mon_wd3 = e.d;
            chk("rf_we", rf_we, e.we);
        end else begin
            chk("rf_we_idle", rf_we, 0);
        end
        chk("rf_a3", rf_a3, mon_a3);
        chk("rf_wd3", rf_wd3, mon_wd3);
    end

    // Entered at posedge+1 with inputs already driven; leaves at the next posedge+1
    task automatic cycle();
        bit g0, g1, iok;
        #1;
        g0  = req0_valid && (!req1_valid || m_last == 1);
        g1  = req1_valid && (!req0_valid || m_last == 0);
        iok = (issue_addr == 0) || !m_busy[issue_addr];
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("issue_ready", issue_ready, iok);
        chk("rs1_busy", rs1_busy, m_busy[rs1]);
        chk("rs2_busy", rs2_busy, m_busy[rs2]);
        if (m_clr > 0) m_busy[m_clr] = 0;
        if (issue_valid && iok && issue_addr != 0) m_busy[issue_addr] = 1;
        m_clr = -1;
        if (g0) begin
            exp_q.push_back('{cyc + 1, req0_addr != 0, req0_addr, req0_data});
            m_last = 0;
            m_clr  = int'(req0_addr);
        end else if (g1) begin
            exp_q.push_back('{cyc + 1, req1_addr != 0, req1_addr, req1_data});
            m_last = 1;
            m_clr  = int'(req1_addr);
        end
        g0_l = g0;
        g1_l = g1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req0_valid  = 0; req1_valid = 0; issue_valid = 0;
        req0_addr   = 0; req1_addr  = 0; issue_addr  = 0;
        req0_data   = 0; req1_data  = 0; rs1 = 0; rs2 = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        exp_q.delete();
        mon_a3  = '0;
        mon_wd3 = '0;
        foreach (m_busy[i]) m_busy[i] = 0;
        m_last = 1;
        m_clr  = -1;
        g0_l   = 0;
        g1_l   = 0;
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_a3", rf_a3, 0);
        chk("rst_rf_wd3", rf_wd3, 0);
        for (int r = 0; r < 32; r++) begin
            rs1 = AW'(r);
            #1;
            chk("rst_busy", rs1_busy, 0);
        end
        rs1 = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        set_idle();
        do_reset();

        // Single ALU write
        req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF;
        cycle();
        set_idle();
        repeat (2) cycle();

        // Contention, each requester drops after its accept
        do_reset();
        req0_valid = 1; req0_addr = 3; req0_data = 32'h11;
        req1_valid = 1; req1_addr = 4; req1_data = 32'h22;
        repeat (4) begin
            cycle();
            if (g0_l) req0_valid = 0;
            if (g1_l) req1_valid = 0;
        end

        // Continuous contention with new data on each accept
        req0_valid = 1; req1_valid = 1;
        repeat (8) begin
            cycle();
            if (g0_l) begin req0_addr = AW'($urandom_range(1, 31)); req0_data = $urandom; end
            if (g1_l) begin req1_addr = AW'($urandom_range(1, 31)); req1_data = $urandom; end
        end
        set_idle();
        cycle();

        // Busy tracking on register 7
        issue_valid = 1; issue_addr = 7; rs1 = 7; rs2 = 7;
        cycle();
        cycle();
        issue_valid = 0;
        req1_valid = 1; req1_addr = 7; req1_data = 32'h0707_0707;
        cycle();
        req1_valid = 0;
        repeat (3) cycle();

        // x0 writes and issues
        req0_valid = 1; req0_addr = 0; req0_data = 32'hFFFFFFFF;
        issue_valid = 1; issue_addr = 0; rs1 = 0; rs2 = 0;
        cycle();
        set_idle();
        issue_valid = 1; issue_addr = 0;
        repeat (2) cycle();
        set_idle();

        // Write landing on reg9 on the same edge a new producer for reg9 issues
        req0_valid = 1; req0_addr = 9; req0_data = 32'h99;
        rs1 = 9;
        cycle();
        req0_valid = 0;
        issue_valid = 1; issue_addr = 9;
        cycle();
        issue_valid = 0;
        repeat (2) cycle();

        // Reset while a write is in flight
        issue_valid = 1; issue_addr = 10; rs2 = 10;
        cycle();
        issue_valid = 0;
        req1_valid = 1; req1_addr = 10; req1_data = 32'hA5A5;
        cycle();
        set_idle();
        do_reset();
        cycle();

        // Randomized traffic; a requester not granted keeps its request unchanged
        repeat (600) begin
            if (!(req0_valid && !g0_l)) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_addr  = AW'($urandom_range(0, 11));
                req0_data  = $urandom;
            end
            if (!(req1_valid && !g1_l)) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_addr  = AW'($urandom_range(0, 11));
                req1_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_addr  = AW'($urandom_range(0, 11));
            rs1         = AW'($urandom_range(0, 11));
            rs2         = AW'($urandom_range(0, 11));
            cycle();
        end
        set_idle();
        repeat (3) cycle();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
